// File: rtl/nx_fp_div_seq_pkg.sv
// Shared SENTINEL divider definitions: FSM state type, divide-by-zero
// result encodings and Q-format range helpers.
package nx_fp_div_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Divide-by-zero result selection
  localparam int DBZ_ONE = 0;  // return fixed-point one
  localparam int DBZ_SAT = 1;  // saturate toward the dividend's sign

  // Largest positive DW-bit two's-complement value, right-aligned in 64 bits
  function automatic logic [63:0] fp_max(input int dw);
    return (64'd1 << (dw - 1)) - 64'd1;
  endfunction

  // Bit pattern of the most negative DW-bit value (also |MIN| as a magnitude)
  function automatic logic [63:0] fp_min(input int dw);
    return 64'd1 << (dw - 1);
  endfunction

endpackage

// File: rtl/nx_fp_div_seq_if.sv
// Operand/result handshake bundle of the sequential divider.
interface nx_fp_div_seq_if
  import nx_fp_div_seq_pkg::*;
#(
  parameter int DW    = 32,
  parameter int TAG_W = 3
);
  logic                    s_valid;
  logic                    s_ready;
  logic signed [DW-1:0]    s_a;
  logic signed [DW-1:0]    s_b;
  logic [TAG_W-1:0]        s_tag;
  logic                    m_valid;
  logic                    m_ready;
  logic signed [DW-1:0]    m_q;
  logic [TAG_W-1:0]        m_tag;
  logic                    m_dbz;
  logic                    m_sat;

  // Requester side
  modport master (
    output s_valid, s_a, s_b, s_tag, m_ready,
    input  s_ready, m_valid, m_q, m_tag, m_dbz, m_sat
  );

  // Divider side
  modport slave (
    input  s_valid, s_a, s_b, s_tag, m_ready,
    output s_ready, m_valid, m_q, m_tag, m_dbz, m_sat
  );
endinterface

// File: rtl/nx_div_step.sv
// Combinational restoring-division step resolving BPC quotient bits.
module nx_div_step
  import nx_fp_div_seq_pkg::*;
#(
  parameter int DW  = 32,
  parameter int BPC = 1
) (
  input  logic [DW:0]     rem_i,
  input  logic [DW:0]     div_i,
  input  logic [BPC-1:0]  num_bits_i,
  output logic [DW:0]     rem_o,
  output logic [BPC-1:0]  q_bits_o
);

  // One spare bit: the shifted remainder is below 2*divisor
  logic [DW+1:0] trial;

  // Shift in numerator bits MSB first; subtract only when it fits
  always_comb begin
    trial    = {1'b0, rem_i};
    q_bits_o = '0;
    for (int i = BPC - 1; i >= 0; i--) begin
      trial = {trial[DW:0], num_bits_i[i]};
      if (trial >= {1'b0, div_i}) begin
        trial       = trial - {1'b0, div_i};
        q_bits_o[i] = 1'b1;
      end
    end
    rem_o = trial[DW:0];
  end

endmodule

// File: rtl/nx_fp_div_seq.sv
// Sequential signed fixed-point divider: q = a/b in the operands' Q format,
// truncated toward zero, saturated, with divide-by-zero and tag passthrough.
module nx_fp_div_seq
  import nx_fp_div_seq_pkg::*;
#(
  parameter int DW       = 32,
  parameter int FW       = 16,
  parameter int BPC      = 1,
  parameter int TAG_W    = 3,
  parameter int DBZ_MODE = DBZ_ONE
) (
  input  logic          clk,
  input  logic          rst_n,
  nx_fp_div_seq_if.slave bus
);

  localparam int NW   = DW + FW;        // numerator |a|<<FW and quotient width
  localparam int ITER = NW / BPC;
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [63:0]   MAX64   = fp_max(DW);
  localparam logic [63:0]   MIN64   = fp_min(DW);
  localparam logic [DW-1:0] Q_MAX   = MAX64[DW-1:0];
  localparam logic [DW-1:0] Q_MIN   = MIN64[DW-1:0];
  localparam logic [DW-1:0] Q_ONE   = DW'(1) << FW;
  localparam logic [NW-1:0] LIM_POS = NW'(Q_MAX);
  localparam logic [NW-1:0] LIM_NEG = NW'(Q_MIN);
  localparam logic [CW-1:0] LAST    = CW'(ITER - 1);

  if (BPC != 1 && BPC != 2 && BPC != 4) begin : g_bad_bpc
    $error("nx_fp_div_seq: BPC must be 1, 2 or 4");
  end
  if ((DW + FW) % BPC != 0) begin : g_bad_split
    $error("nx_fp_div_seq: DW+FW must be a multiple of BPC");
  end
  if (FW >= DW || DW > 64) begin : g_bad_fmt
    $error("nx_fp_div_seq: need FW < DW <= 64");
  end

  // Sign-magnitude of a DW-bit operand; |MIN| needs the extra bit
  function automatic logic [DW:0] mag_ext(input logic signed [DW-1:0] v);
    return v[DW-1] ? (~{v[DW-1], v} + 1'b1) : {v[DW-1], v};
  endfunction

  // Apply sign and clip to the DW range; returns {sat, q}
  function automatic logic [DW:0] sat_quot(input logic [NW-1:0] mag,
                                           input logic neg);
    logic          sat;
    logic [DW-1:0] q;
    if (neg) begin
      sat = (mag > LIM_NEG);
      q   = sat ? Q_MIN : -mag[DW-1:0];
    end else begin
      sat = (mag > LIM_POS);
      q   = sat ? Q_MAX : mag[DW-1:0];
    end
    return {sat, q};
  endfunction

  // Divide-by-zero result
  function automatic logic [DW-1:0] dbz_quot(input logic a_neg);
    if (DBZ_MODE == DBZ_SAT) return a_neg ? Q_MIN : Q_MAX;
    else                     return Q_ONE;
  endfunction

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NW-1:0]    num_q, quo_q;
  logic [DW:0]      den_q, rem_q, step_rem;
  logic [BPC-1:0]   step_q;
  logic             neg_q, a_neg_q, dbz_q;
  logic [TAG_W-1:0] tag_q;
  logic             mv_q, mdbz_q, msat_q;
  logic [DW-1:0]    mq_q;
  logic [TAG_W-1:0] mtag_q;
  logic             accept;
  logic [DW:0]      a_mag, b_mag, res;

  assign accept = (state_q == ST_IDLE) && bus.s_valid;
  assign a_mag  = mag_ext(bus.s_a);
  assign b_mag  = mag_ext(bus.s_b);
  assign res    = sat_quot(quo_q, neg_q);

  nx_div_step #(.DW(DW), .BPC(BPC)) u_step (
    .rem_i      (rem_q),
    .div_i      (den_q),
    .num_bits_i (num_q[NW-1 -: BPC]),
    .rem_o      (step_rem),
    .q_bits_o   (step_q)
  );

  // FSM state and iteration counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: zero divisor skips the iterations entirely
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.s_valid) state_d = (bus.s_b == '0) ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (mv_q && bus.m_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs come from state and the result registers
  always_comb begin
    bus.s_ready = (state_q == ST_IDLE);
    bus.m_valid = mv_q;
    bus.m_q     = mq_q;
    bus.m_tag   = mtag_q;
    bus.m_dbz   = mdbz_q;
    bus.m_sat   = msat_q;
  end

  // Operand capture on accept, then one restoring step per CALC cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      num_q   <= NW'(a_mag) << FW;
      den_q   <= b_mag;
      rem_q   <= '0;
      quo_q   <= '0;
      neg_q   <= bus.s_a[DW-1] ^ bus.s_b[DW-1];
      a_neg_q <= bus.s_a[DW-1];
      dbz_q   <= (bus.s_b == '0);
      tag_q   <= bus.s_tag;
    end else if (state_q == ST_CALC) begin
      num_q <= num_q << BPC;
      rem_q <= step_rem;
      quo_q <= {quo_q[NW-BPC-1:0], step_q};
    end
  end

  // First DONE cycle signs/clips the quotient into the held result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mv_q   <= 1'b0;
      mq_q   <= '0;
      mtag_q <= '0;
      mdbz_q <= 1'b0;
      msat_q <= 1'b0;
    end else if (state_q == ST_DONE && !mv_q) begin
      mv_q   <= 1'b1;
      mtag_q <= tag_q;
      mdbz_q <= dbz_q;
      if (dbz_q) begin
        mq_q   <= dbz_quot(a_neg_q);
        msat_q <= 1'b0;
      end else begin
        mq_q   <= res[DW-1:0];
        msat_q <= res[DW];
      end
    end else if (mv_q && bus.m_ready) begin
      mv_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nx_fp_div_seq.sv
// Scoreboard bench for nx_fp_div_seq: instance 0 (BPC=1, DBZ one),
// instance 1 (BPC=2, DBZ saturate).
module tb_nx_fp_div_seq;

  typedef struct {
    logic [31:0] q;
    logic [2:0]  tag;
    logic        dbz;
    logic        sat;
    int          acc;
    int          lat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  logic        sv[2];
  logic [31:0] sa[2], sb[2];
  logic [2:0]  stg[2];
  logic        mr[2];
  logic        sr[2], mv[2], mdbz[2], msat[2];
  logic [31:0] mq[2];
  logic [2:0]  mtg[2];

  exp_t expq[2][$];
  exp_t cur[2];
  logic have_cur[2];
  logic busy[2];
  int   rdy_mode[2];
  logic rdy_force[2];

  nx_fp_div_seq_if #(.DW(32), .TAG_W(3)) if0 ();
  nx_fp_div_seq_if #(.DW(32), .TAG_W(3)) if1 ();

  assign if0.s_valid = sv[0];
  assign if0.s_a     = sa[0];
  assign if0.s_b     = sb[0];
  assign if0.s_tag   = stg[0];
  assign if0.m_ready = mr[0];
  assign sr[0]   = if0.s_ready;
  assign mv[0]   = if0.m_valid;
  assign mq[0]   = if0.m_q;
  assign mtg[0]  = if0.m_tag;
  assign mdbz[0] = if0.m_dbz;
  assign msat[0] = if0.m_sat;

  assign if1.s_valid = sv[1];
  assign if1.s_a     = sa[1];
  assign if1.s_b     = sb[1];
  assign if1.s_tag   = stg[1];
  assign if1.m_ready = mr[1];
  assign sr[1]   = if1.s_ready;
  assign mv[1]   = if1.m_valid;
  assign mq[1]   = if1.m_q;
  assign mtg[1]  = if1.m_tag;
  assign mdbz[1] = if1.m_dbz;
  assign msat[1] = if1.m_sat;

  nx_fp_div_seq #(.DW(32), .FW(16), .BPC(1), .TAG_W(3), .DBZ_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  nx_fp_div_seq #(.DW(32), .FW(16), .BPC(2), .TAG_W(3), .DBZ_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: real-valued a/b scaled by 2^16, truncated toward zero, then clipped
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] tag, input int mode, input int bpc);
    exp_t   e;
    longint la, lb, qq;
    la    = longint'($signed(a));
    lb    = longint'($signed(b));
    e.tag = tag;
    e.acc = 0;
    if (b == 32'h0) begin
      e.dbz = 1'b1;
      e.sat = 1'b0;
      e.lat = 1;
      if (mode == 1) e.q = (la < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      else           e.q = 32'h0001_0000;
    end else begin
      e.dbz = 1'b0;
      e.lat = 48 / bpc + 1;
      qq    = (la * 65536) / lb;
      if (qq > 64'sd2147483647) begin
        e.q = 32'h7FFF_FFFF; e.sat = 1'b1;
      end else if (qq < -64'sd2147483648) begin
        e.q = 32'h8000_0000; e.sat = 1'b1;
      end else begin
        e.q = qq[31:0]; e.sat = 1'b0;
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] rnd_op(input bit allow_zero);
    logic [31:0] v;
    v = $urandom();
    case ($urandom_range(0, 6))
      0: return v;
      1: begin
        v = $urandom_range(1, 32'h0004_0000);
        return ($urandom_range(0, 1) == 1) ? -v : v;
      end
      2: return allow_zero ? 32'h0 : 32'h0000_0001;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return {v[15:0], 16'h0};
      default: return v >> $urandom_range(0, 28);
    endcase
  endfunction

  function automatic logic [31:0] rnd_div();
    if ($urandom_range(0, 9) == 0) return 32'h0;
    return rnd_op(1'b0);
  endfunction

  // Present one request and push its expected result when it is taken
  task automatic send(input int k, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] tag);
    exp_t e;
    logic ok;
    ok      = 1'b0;
    busy[k] = 1'b1;
    e = model(a, b, tag, (k == 1) ? 1 : 0, (k == 1) ? 2 : 1);
    @(posedge clk); #1;
    sa[k] = a; sb[k] = b; stg[k] = tag; sv[k] = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (sr[k]) begin
        e.acc = cyc + 1;
        expq[k].push_back(e);
        ok = 1'b1;
      end
    end
    @(posedge clk); #1;
    sv[k] = 1'b0;
    if (!ok) chk($sformatf("accept_timeout%0d", k), ok, 1);
    busy[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      if (expq[k].size() == 0 && !have_cur[k] && !busy[k]) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) chk($sformatf("drain_timeout%0d", k), done, 1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready: always, random, or forced by the main sequence
  initial begin
    mr[0] = 1'b1; mr[1] = 1'b1;
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++)
        mr[k] = (rdy_mode[k] == 0) ? 1'b1 :
                (rdy_mode[k] == 1) ? 1'($urandom_range(0, 1)) : rdy_force[k];
    end
  end

  // Monitor: pop on each new result, then hold-stability until the handshake
  initial begin
    have_cur[0] = 1'b0; have_cur[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst_n && mv[k]) begin
          if (!have_cur[k]) begin
            if (expq[k].size() == 0) begin
              chk($sformatf("unexpected_valid%0d", k), mv[k], 0);
            end else begin
              cur[k]      = expq[k].pop_front();
              have_cur[k] = 1'b1;
              chk($sformatf("q%0d", k),       mq[k],   cur[k].q);
              chk($sformatf("tag%0d", k),     mtg[k],  cur[k].tag);
              chk($sformatf("dbz%0d", k),     mdbz[k], cur[k].dbz);
              chk($sformatf("sat%0d", k),     msat[k], cur[k].sat);
              chk($sformatf("latency%0d", k), cyc - cur[k].acc, cur[k].lat);
            end
          end else begin
            chk($sformatf("hold_q%0d", k),   mq[k],  cur[k].q);
            chk($sformatf("hold_tag%0d", k), mtg[k], cur[k].tag);
          end
          if (mr[k]) have_cur[k] = 1'b0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached with %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   seen;
    for (int k = 0; k < 2; k++) begin
      sv[k] = 1'b0; sa[k] = '0; sb[k] = '0; stg[k] = '0;
      busy[k] = 1'b0; rdy_mode[k] = 0; rdy_force[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_s_ready%0d", k), sr[k],   1);
      chk($sformatf("rst_m_valid%0d", k), mv[k],   0);
      chk($sformatf("rst_m_q%0d", k),     mq[k],   0);
      chk($sformatf("rst_m_tag%0d", k),   mtg[k],  0);
      chk($sformatf("rst_m_dbz%0d", k),   mdbz[k], 0);
      chk($sformatf("rst_m_sat%0d", k),   msat[k], 0);
    end

    // Directed cases
    send(0, 32'h0001_8000, 32'h0000_8000, 3'd5);
    send(0, 32'hFFFF_0000, 32'h0003_0000, 3'd1);
    send(0, 32'h8000_0000, 32'hFFFF_0000, 3'd2);
    send(0, 32'h7FFF_0000, 32'h0000_0100, 3'd3);
    send(0, 32'h8000_0000, 32'h0001_0000, 3'd4);
    send(0, 32'hFFFE_0000, 32'h0000_0000, 3'd6);
    send(0, 32'h0000_0000, 32'hFFFB_0000, 3'd7);
    drain(0);

    // Backpressure: result held, a second request waits
    rdy_mode[0] = 2; rdy_force[0] = 1'b0;
    send(0, 32'h0006_0000, 32'h0002_0000, 3'd6);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (mv[0]) ok = 1'b1;
    end
    if (!ok) chk("stall_valid_timeout", ok, 1);
    fork
      send(0, 32'h0001_0000, 32'h0004_0000, 3'd1);
    join_none
    repeat (10) begin
      @(negedge clk);
      chk("stall_s_ready", sr[0], 0);
      chk("stall_m_valid", mv[0], 1);
    end
    rdy_force[0] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (mv[0] && mr[0]) ok = 1'b1;
    end
    if (!ok) chk("release_timeout", ok, 1);
    @(negedge clk);
    chk("s_ready_after_release", sr[0], 1);
    drain(0);
    rdy_mode[0] = 0;

    // Reset in the middle of an iteration abandons the request
    send(0, 32'h1234_0000, 32'h0003_0000, 3'd2);
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    expq[0].delete();
    have_cur[0] = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_ready", sr[0], 1);
    chk("post_rst_m_valid", mv[0], 0);
    chk("post_rst_m_q",     mq[0], 0);
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (mv[0]) seen++;
    end
    chk("no_stale_valid", seen, 0);
    send(0, 32'h0004_0000, 32'h0002_0000, 3'd3);
    drain(0);

    // Randomized traffic with random downstream backpressure
    rdy_mode[0] = 1;
    repeat (150) send(0, rnd_op(1'b1), rnd_div(), 3'($urandom_range(0, 7)));
    drain(0);
    rdy_mode[0] = 0;

    // Two-bits-per-cycle, saturating divide-by-zero instance
    send(1, 32'h0001_8000, 32'h0000_8000, 3'd5);
    send(1, 32'hFFFE_0000, 32'h0000_0000, 3'd2);
    send(1, 32'h7FFF_0000, 32'h0000_0000, 3'd1);
    send(1, 32'hFFFF_0000, 32'h0003_0000, 3'd4);
    send(1, 32'h8000_0000, 32'hFFFF_0000, 3'd6);
    rdy_mode[1] = 1;
    repeat (40) send(1, rnd_op(1'b1), rnd_div(), 3'($urandom_range(0, 7)));
    drain(1);
    rdy_mode[1] = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
